logic_pod_chunk_packer: RTL and testbench
=========================================

Name: logic_pod_chunk_packer

Overview:
- Sits directly downstream of the per-lane logic pod compression engine.
- Accepts its 17-bit chunk stream (valid pulse, format bit, 16 data bits) with no backpressure.
- Packs chunks MSB-first, bit-contiguous, into OUT_WIDTH-bit words.
- Buffers packed words in an internal FIFO and presents them on a valid/ready interface to the capture-memory writer.
- Supports zero-padded flush at end of capture, sticky overflow reporting and an accepted-chunk counter.

Parameters:
OUT_WIDTH, 64, output word width in bits; legal range 32..256, multiple of 8.
FIFO_DEPTH, 16, output FIFO depth in words; power of two, at least 4.

Ports:
clk  in  1  capture clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  chunk present this cycle
in_format  in  1  chunk format bit; packed as chunk MSB
in_data  in  16  chunk payload; chunk = {in_format, in_data}
flush  in  1  single-cycle request: pad partial word with zeros and emit it
out_valid  out  1  FIFO head word valid
out_ready  in  1  consumer accepts head word when out_valid & out_ready
out_data  out  OUT_WIDTH  packed word; earliest chunk bits at MSB
out_last  out  1  head word is the final word of a flush
flush_done  out  1  one-cycle pulse when flush processing completes
overflow  out  1  sticky: a word was dropped because the FIFO was full
overflow_clr  in  1  clears overflow
chunk_count  out  32  chunks accepted since reset; wraps at 2^32

Behaviour:
Reset state:
- Asynchronous reset clears the accumulator, fill count, FIFO pointers and pending-flush state.
- All outputs are 0 during and after reset.

Accumulator:
- Register of OUT_WIDTH+16 bits plus fill count 0..OUT_WIDTH-1.
- On in_valid, the chunk is appended immediately below the existing fill bits.
- If fill+17 >= OUT_WIDTH:
  - The top OUT_WIDTH bits form a completed word.
  - The remainder (fill+17-OUT_WIDTH bits) is left-aligned into the accumulator.
  - fill becomes that remainder count.
- Otherwise fill += 17.
- At most one word completes per cycle; 17 < OUT_WIDTH guarantees this.

Latency:
- Word completed by a chunk on cycle N is written to the FIFO at the end of cycle N+1.
- With the FIFO empty, out_valid is high on cycle N+2.
- FIFO is first-word-fall-through.
- out_data and out_last hold stable while out_valid & !out_ready.

Flush:
- flush on cycle N with fill>0:
  - The partial word is zero-padded in the LSBs.
  - It is pushed with out_last=1.
  - fill returns to 0.
  - flush_done pulses on cycle N+2.
- flush with fill==0: no word is pushed; flush_done pulses on N+2.
- in_valid and flush in the same cycle: the chunk is appended first, then the flush applies.
  - If that chunk completes a word, two words are pushed on consecutive cycles (full word, then padded remainder with out_last=1, if remainder>0).
  - The packer accepts in_valid on the following cycle without loss; a one-entry skid holds the second word.
  - flush_done pulses the cycle after the last push.
- flush while a previous flush is pending is ignored.

FIFO:
- Push and pop in the same cycle is allowed; occupancy is unchanged.
- Full FIFO with no simultaneous pop at push time:
  - The word is dropped.
  - overflow is set the next cycle.
  - Accumulator state advances as if pushed.
- overflow_clr in the same cycle as a new drop: overflow stays set (set wins).
- Empty FIFO: out_valid=0, out_data holds last value (don't-care).

chunk_count:
- Increments by 1 per in_valid, independent of overflow.
- Updates the cycle after acceptance.

Test Plan:
- OUT_WIDTH=64, out_ready=1, four chunks 17'h1FFFF on consecutive cycles -> one word 0xFFFFFFFFFFFFFFFF on out_valid two cycles after the 4th chunk, out_last=0; fill=4; chunk_count=4.
- Reset, one chunk {1,16'h2345}, flush next cycle -> single word 0x91A2800000000000 with out_last=1; flush_done pulses once; fill=0.
- Continuous 17'h0A5A5 chunks for 64 cycles, out_ready=1 -> 17 words emitted; concatenated bitstream reproduces the chunk sequence exactly; no overflow.
- out_ready=0, continuous chunks until FIFO_DEPTH=16 words queued plus one more completed -> overflow=1, exactly 16 words drain when out_ready=1; overflow_clr clears it.
- Chunk completing a word and flush in the same cycle (fill=60) -> two pushes: full word, then word with 13 valid MSBs and out_last=1; flush_done after the second; chunk on the following cycle is not lost.
- Assert rst mid-stream with 3 words queued and fill=34 -> out_valid, overflow, chunk_count, flush_done go 0 immediately; next four chunks produce a word aligned from bit 63.

Source files
------------

// File: rtl/logic_pod_chunk_packer.sv
// Packs 17-bit compression-engine chunks MSB-first into OUT_WIDTH-bit words,
// queues them in a first-word-fall-through FIFO with flush, overflow and chunk counting.
module logic_pod_chunk_packer #(
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_format,
    input  logic [15:0]          in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 flush_done,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic [31:0]          chunk_count
);
    localparam int FW = $clog2(OUT_WIDTH);
    localparam int SW = FW + 1;
    localparam int CW = OUT_WIDTH + 17;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [OUT_WIDTH-1:0] r_acc;
    logic [FW-1:0]        r_fill;
    logic                 r_s1_vld, r_s1_last, r_s1_done;
    logic [OUT_WIDTH-1:0] r_s1_word;
    logic                 r_skid_vld;
    logic [OUT_WIDTH-1:0] r_skid_word;
    logic                 r_flush_done, r_overflow;
    logic [31:0]          r_count;
    logic [OUT_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wp, r_rp;

    logic [16:0]          w_chunk;
    logic [SW-1:0]        w_sum;
    logic [CW-1:0]        w_ins, w_comb;
    logic                 w_cmp, w_flush, w_pending;
    logic [OUT_WIDTH-1:0] w_word, w_rem, w_nacc;
    logic [FW-1:0]        w_nfill;
    logic                 w_full, w_pop, w_push, w_drop;
    logic [OUT_WIDTH:0]   w_head;

    // New chunk lands directly below the current fill bits of the accumulator.
    assign w_chunk   = {in_format, in_data};
    assign w_sum     = {1'b0, r_fill} + (in_valid ? SW'(17) : SW'(0));
    assign w_ins     = {w_chunk, {OUT_WIDTH{1'b0}}} >> r_fill;
    assign w_comb    = {r_acc, 17'b0} | (in_valid ? w_ins : '0);
    assign w_cmp     = w_sum >= SW'(OUT_WIDTH);
    assign w_word    = w_comb[CW-1 -: OUT_WIDTH];
    assign w_rem     = {w_comb[16:0], {(OUT_WIDTH-17){1'b0}}};
    assign w_nacc    = w_cmp ? w_rem : w_word;
    assign w_nfill   = w_cmp ? FW'(w_sum - SW'(OUT_WIDTH)) : FW'(w_sum);
    assign w_pending = r_skid_vld | r_s1_done;
    assign w_flush   = flush & ~w_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_done   <= 1'b0;
            r_s1_word   <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_word <= '0;
            r_count     <= '0;
        end else begin
            r_count <= r_count + {31'd0, in_valid};
            if (w_flush) begin
                r_acc  <= '0;
                r_fill <= '0;
            end else begin
                r_acc  <= w_nacc;
                r_fill <= w_nfill;
            end
            // A flush can never follow a pending skid word, and fill is 0 here,
            // so no chunk can complete a word in the same cycle the skid drains.
            if (r_skid_vld) begin
                r_s1_vld   <= 1'b1;
                r_s1_word  <= r_skid_word;
                r_s1_last  <= 1'b1;
                r_s1_done  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_flush && w_cmp) begin
                r_s1_vld    <= 1'b1;
                r_s1_word   <= w_word;
                r_s1_last   <= (w_nfill == '0);
                r_s1_done   <= (w_nfill == '0);
                r_skid_vld  <= (w_nfill != '0);
                r_skid_word <= w_rem;
            end else if (w_flush) begin
                r_s1_vld  <= (w_nfill != '0);
                r_s1_word <= w_word;
                r_s1_last <= 1'b1;
                r_s1_done <= 1'b1;
            end else begin
                r_s1_vld  <= w_cmp;
                r_s1_word <= w_word;
                r_s1_last <= 1'b0;
                r_s1_done <= 1'b0;
            end
        end
    end

    assign out_valid = (r_wp != r_rp);
    assign w_full    = (r_wp - r_rp) == (AW+1)'(FIFO_DEPTH);
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_s1_vld & (~w_full | w_pop);
    assign w_drop    = r_s1_vld & w_full & ~w_pop;
    assign w_head    = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= {r_s1_last, r_s1_word};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_flush_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_flush_done <= r_s1_done;
            // A fresh drop outranks a simultaneous clear.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (overflow_clr)
                r_overflow <= 1'b0;
        end
    end

    assign out_data    = out_valid ? w_head[OUT_WIDTH-1:0] : '0;
    assign out_last    = out_valid & w_head[OUT_WIDTH];
    assign flush_done  = r_flush_done;
    assign overflow    = r_overflow;
    assign chunk_count = r_count;
endmodule

// File: tb/tb_logic_pod_chunk_packer.sv
// Directed bench for logic_pod_chunk_packer: bit-queue reference model plus
// cycle-exact checks of latency, flush, overflow and reset behaviour.
module tb_logic_pod_chunk_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_format = 1'b0, flush = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid, out_ready = 1'b1, out_last;
    logic [63:0] out_data;
    logic        flush_done, overflow, overflow_clr = 1'b0;
    logic [31:0] chunk_count;

    logic_pod_chunk_packer #(.OUT_WIDTH(64), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_format(in_format),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .flush_done(flush_done), .overflow(overflow),
        .overflow_clr(overflow_clr), .chunk_count(chunk_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    logic [64:0] cap[$];
    int nfd = 0;
    int cap_base, fd_base;
    bit mq[$];
    logic [64:0] expq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) cap.push_back({out_last, out_data});
            if (flush_done) nfd++;
        end
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_chunk(input logic [16:0] c);
        logic [63:0] w;
        for (int i = 16; i >= 0; i--) mq.push_back(c[i]);
        if (mq.size() >= 64) begin
            w = '0;
            for (int i = 63; i >= 0; i--) w[i] = mq.pop_front();
            expq.push_back({1'b0, w});
        end
    endtask

    task automatic model_flush();
        logic [63:0] w;
        if (mq.size() > 0) begin
            w = '0;
            for (int i = 63; i >= 0; i--) if (mq.size() > 0) w[i] = mq.pop_front();
            expq.push_back({1'b1, w});
        end
    endtask

    task automatic drive(input logic v, input logic [16:0] c, input logic f);
        in_valid = v;
        {in_format, in_data} = c;
        flush = f;
        if (v) model_chunk(c);
        if (f) model_flush();
        step();
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; overflow_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        mq.delete(); expq.delete();
        cap_base = cap.size();
        fd_base  = nfd;
    endtask

    task automatic cmp_stream(input string tag, input int n);
        chk({tag, "_cnt"}, 80'(cap.size() - cap_base), 80'(n));
        for (int i = 0; i < n; i++)
            if (cap_base + i < cap.size() && i < expq.size())
                chk($sformatf("%s_w%0d", tag, i), 80'(cap[cap_base + i]), 80'(expq[i]));
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        step();
        chk("rst_valid", 80'(out_valid), 80'd0);
        chk("rst_data",  80'(out_data), 80'd0);
        chk("rst_last",  80'(out_last), 80'd0);
        chk("rst_ovf",   80'(overflow), 80'd0);
        chk("rst_fdone", 80'(flush_done), 80'd0);
        chk("rst_count", 80'(chunk_count), 80'd0);

        // four all-ones chunks -> one all-ones word two cycles after the 4th
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 17'h1FFFF, 1'b0);
        chk("t1_early", 80'(out_valid), 80'd0);
        step();
        chk("t1_valid", 80'(out_valid), 80'd1);
        chk("t1_data",  80'(out_data), 80'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_last",  80'(out_last), 80'd0);
        chk("t1_count", 80'(chunk_count), 80'd4);
        drive(1'b0, 17'h0, 1'b1);
        step(); step(); step();
        cmp_stream("t1", 2);
        chk("t1_rem4", 80'(cap[cap.size()-1]), {15'd0, 1'b1, 64'hF000_0000_0000_0000});

        // single chunk + flush
        do_reset();
        drive(1'b1, {1'b1, 16'h2345}, 1'b0);
        drive(1'b0, 17'h0, 1'b1);
        chk("t2_fd_n1", 80'(flush_done), 80'd0);
        step();
        chk("t2_fd_n2", 80'(flush_done), 80'd1);
        chk("t2_data",  80'(out_data), 80'h91A2_8000_0000_0000);
        chk("t2_last",  80'(out_last), 80'd1);
        step();
        chk("t2_fd_n3", 80'(flush_done), 80'd0);
        step(); step();
        cmp_stream("t2", 1);
        chk("t2_fdcnt", 80'(nfd - fd_base), 80'd1);

        // 64 identical chunks -> 17 exact words
        do_reset();
        for (int i = 0; i < 64; i++) drive(1'b1, 17'h0A5A5, 1'b0);
        for (int i = 0; i < 4; i++) step();
        cmp_stream("t3", 17);
        chk("t3_ovf", 80'(overflow), 80'd0);
        chk("t3_count", 80'(chunk_count), 80'd64);

        // overflow: 17 words completed with a stalled consumer
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) drive(1'b1, 17'(i * 37 + 5), 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("t4_ovf_set", 80'(overflow), 80'd1);
        chk("t4_valid", 80'(out_valid), 80'd1);
        chk("t4_head", 80'(out_data), 80'(expq[0][63:0]));
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        cmp_stream("t4", 16);
        chk("t4_ovf_hold", 80'(overflow), 80'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("t4_ovf_clr", 80'(overflow), 80'd0);

        // chunk completes a word at fill=60 together with flush
        do_reset();
        for (int i = 0; i < 60; i++) drive(1'b1, 17'(i * 37 + 5), 1'b0);
        drive(1'b1, 17'h1ABCD, 1'b1);
        chk("t5_fd_n1", 80'(flush_done), 80'd0);
        drive(1'b1, 17'h0F0F1, 1'b0);
        chk("t5_fd_n2", 80'(flush_done), 80'd0);
        step();
        chk("t5_fd_n3", 80'(flush_done), 80'd1);
        step();
        chk("t5_fd_n4", 80'(flush_done), 80'd0);
        drive(1'b0, 17'h0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        cmp_stream("t5", 18);
        chk("t5_fdcnt", 80'(nfd - fd_base), 80'd2);

        // asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 17'(i + 1), 1'b1);
            step();
        end
        drive(1'b1, 17'h11111, 1'b0);
        drive(1'b1, 17'h02222, 1'b0);
        step(); step();
        chk("t6_valid_pre", 80'(out_valid), 80'd1);
        chk("t6_count_pre", 80'(chunk_count), 80'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_rst", 80'(out_valid), 80'd0);
        chk("t6_count_rst", 80'(chunk_count), 80'd0);
        chk("t6_ovf_rst",   80'(overflow), 80'd0);
        chk("t6_fd_rst",    80'(flush_done), 80'd0);
        step();
        rst = 1'b0;
        mq.delete(); expq.delete();
        cap_base = cap.size();
        out_ready = 1'b1;
        drive(1'b1, 17'h1F00F, 1'b0);
        drive(1'b1, 17'h00FF0, 1'b0);
        drive(1'b1, 17'h13579, 1'b0);
        drive(1'b1, 17'h0ACE1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        cmp_stream("t6", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
